// File: rtl/elevator_motion_ctrl.sv
// Car motion controller: drives the motor toward a latched target floor, tracks
// car position, and holds the door open for a fixed dwell after each arrival.
module elevator_motion_ctrl #(
    parameter int TRAVEL_CYCLES = 100_000_000,
    parameter int DOOR_CYCLES   = 150_000_000,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tgt_floor,
    input  logic       tgt_valid,
    output logic [1:0] pos_floor,
    output logic       mot_up,
    output logic       mot_dn,
    output logic       door_open,
    output logic       busy,
    output logic       arrived
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MOVE_UP = 2'b01,
        MOVE_DN = 2'b10,
        DOOR    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_r;
    logic [1:0]       tgt_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             req_ok_s;
    logic [1:0]       pos_up_s;
    logic [1:0]       pos_dn_s;

    // Request qualification and neighbour-floor arithmetic.
    always_comb begin
        req_ok_s = tgt_valid && (tgt_floor != 2'b11);
        pos_up_s = pos_floor + 2'd1;
        pos_dn_s = pos_floor - 2'd1;
    end

    // Motion FSM with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            tgt_q_r   <= 2'b00;
            cnt_r     <= CNT_ZERO;
            pos_floor <= 2'b00;
            mot_up    <= 1'b0;
            mot_dn    <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            arrived <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_ok_s) begin
                        cnt_r <= CNT_ZERO;
                        busy  <= 1'b1;
                        if (tgt_floor > pos_floor) begin
                            tgt_q_r <= tgt_floor;
                            state_r <= MOVE_UP;
                            mot_up  <= 1'b1;
                        end else if (tgt_floor < pos_floor) begin
                            tgt_q_r <= tgt_floor;
                            state_r <= MOVE_DN;
                            mot_dn  <= 1'b1;
                        end else begin
                            state_r   <= DOOR;
                            door_open <= 1'b1;
                        end
                    end
                end
                MOVE_UP: begin
                    if (pos_floor == 2'b10) begin
                        // Top floor cannot be exceeded; abandon the move rather than wrap.
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        mot_up  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (cnt_r == TRAVEL_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        pos_floor <= pos_up_s;
                        if (pos_up_s == tgt_q_r) begin
                            state_r   <= DOOR;
                            mot_up    <= 1'b0;
                            door_open <= 1'b1;
                            arrived   <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                MOVE_DN: begin
                    if (pos_floor == 2'b00) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        mot_dn  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (cnt_r == TRAVEL_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        pos_floor <= pos_dn_s;
                        if (pos_dn_s == tgt_q_r) begin
                            state_r   <= DOOR;
                            mot_dn    <= 1'b0;
                            door_open <= 1'b1;
                            arrived   <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DOOR: begin
                    // A same-floor press while open restarts the dwell.
                    if (req_ok_s && (tgt_floor == pos_floor)) begin
                        cnt_r <= CNT_ZERO;
                    end else if (cnt_r == DOOR_LAST) begin
                        state_r   <= IDLE;
                        cnt_r     <= CNT_ZERO;
                        door_open <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    mot_up    <= 1'b0;
                    mot_dn    <= 1'b0;
                    door_open <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: directed scenarios plus random traffic, all
// checked against a countdown-based behavioural model of the car.
module tb_elevator_motion_ctrl;

    localparam int T = 4;
    localparam int D = 3;

    logic       clk;
    logic       reset;
    logic [1:0] tgt_floor;
    logic       tgt_valid;
    logic [1:0] pos_floor;
    logic       mot_up;
    logic       mot_dn;
    logic       door_open;
    logic       busy;
    logic       arrived;

    int n_cmp;
    int n_fail;

    // Behavioural model: direction, remaining cycles in the current leg or dwell.
    int m_pos;
    int m_tgt;
    int m_dir;
    int m_left;
    bit m_door;
    bit m_arr;

    elevator_motion_ctrl #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .tgt_floor(tgt_floor), .tgt_valid(tgt_valid),
        .pos_floor(pos_floor), .mot_up(mot_up), .mot_dn(mot_dn),
        .door_open(door_open), .busy(busy), .arrived(arrived)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_tick(input bit r, input bit v, input int f);
        if (r) begin
            m_pos = 0; m_tgt = 0; m_dir = 0; m_left = 0; m_door = 1'b0; m_arr = 1'b0;
        end else begin
            m_arr = 1'b0;
            if (m_dir != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_pos += m_dir;
                    if (m_pos == m_tgt) begin
                        m_dir = 0; m_door = 1'b1; m_left = D; m_arr = 1'b1;
                    end else begin
                        m_left = T;
                    end
                end
            end else if (m_door) begin
                if (v && f == m_pos) m_left = D;
                else begin
                    m_left--;
                    if (m_left == 0) m_door = 1'b0;
                end
            end else if (v && f != 3) begin
                if (f == m_pos) begin
                    m_door = 1'b1; m_left = D;
                end else begin
                    m_tgt = f; m_left = T; m_dir = (f > m_pos) ? 1 : -1;
                end
            end
        end
    endtask

    function automatic logic [6:0] exp_vec();
        logic [1:0] p;
        p = 2'(m_pos);
        return {p, m_dir == 1, m_dir == -1, m_door, (m_dir != 0) || m_door, m_arr};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {pos_floor, mot_up, mot_dn, door_open, busy, arrived};
    endfunction

    task automatic step(input bit r, input bit v, input logic [1:0] f);
        reset = r; tgt_valid = v; tgt_floor = f;
        @(posedge clk);
        model_tick(r, v, int'(f));
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 2'b10);
            n_cmp++;
            if (obs_vec() !== 7'b0000000) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b want 0000000", i, obs_vec());
            end
        end
        step(1'b0, 1'b1, 2'b10);
        n_cmp++;
        if ({mot_up, busy, door_open} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_release_accept: got up/busy/door %b want 110", {mot_up, busy, door_open});
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 2'b00);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_follow cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ground_to_second();
        int ups, doors, arrs, pos1_at, pos2_at;
        ups = 0; doors = 0; arrs = 0; pos1_at = -1; pos2_at = -1;
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, i == 0, 2'b10);
            ups += int'(mot_up); doors += int'(door_open); arrs += int'(arrived);
            if (pos1_at < 0 && pos_floor == 2'b01) pos1_at = i;
            if (pos2_at < 0 && pos_floor == 2'b10) pos2_at = i;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL up_trace cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (ups != 2 * T || doors != D || arrs != 1 || pos1_at != T || pos2_at != 2 * T || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL up_summary: got up=%0d door=%0d arr=%0d p1@%0d p2@%0d busy=%b want 8 3 1 4 8 0",
                     ups, doors, arrs, pos1_at, pos2_at, busy);
        end
    endtask

    task automatic test_down_ignore();
        int dns, arrs;
        dns = 0; arrs = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) step(1'b0, 1'b1, 2'b00);
            else if (i == 3) step(1'b0, 1'b1, 2'b01);
            else step(1'b0, 1'b0, 2'b00);
            dns += int'(mot_dn); arrs += int'(arrived);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL down_trace cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dns != 2 * T || arrs != 1 || pos_floor !== 2'b00) begin
            n_fail++;
            $display("FAIL down_summary: got dn=%0d arr=%0d pos=%b want 8 1 00", dns, arrs, pos_floor);
        end
    endtask

    task automatic test_same_floor();
        int doors, arrs;
        for (int run = 0; run < 2; run++) begin
            doors = 0; arrs = 0;
            for (int i = 0; i < 10; i++) begin
                step(1'b0, (i == 0) || (run == 1 && i == 2), 2'b00);
                doors += int'(door_open); arrs += int'(arrived);
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL same_trace run %0d cyc %0d: got %b want %b", run, i, obs_vec(), exp_vec());
                end
            end
            n_cmp++;
            if (doors != ((run == 1) ? D + 2 : D) || arrs != 0) begin
                n_fail++;
                $display("FAIL same_summary run %0d: got door=%0d arr=%0d want %0d 0",
                         run, doors, arrs, (run == 1) ? D + 2 : D);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2'b11);
            n_cmp++;
            if (obs_vec() !== 7'b0000000) begin
                n_fail++;
                $display("FAIL invalid_floor cyc %0d: got %b want 0000000", i, obs_vec());
            end
        end
    endtask

    task automatic test_reset_mid_travel();
        int arrs;
        arrs = 0;
        for (int i = 0; i < 8; i++) begin
            step(i == 6, i == 0, 2'b10);
            arrs += int'(arrived);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL midreset_trace cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i == 6) begin
                n_cmp++;
                if (obs_vec() !== 7'b0000000 || arrs != 0) begin
                    n_fail++;
                    $display("FAIL midreset_state: got %b arr=%0d want 0000000 0", obs_vec(), arrs);
                end
            end
        end
    endtask

    task automatic test_random();
        bit r, v;
        logic [1:0] f;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 3);
            f = 2'($urandom_range(0, 3));
            step(r, v, f);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            if ((int'(mot_up) + int'(mot_dn) + int'(door_open)) > 1 || pos_floor === 2'b11) begin
                n_fail++;
                $display("FAIL random_exclusive cyc %0d: got up/dn/door/pos %b%b%b/%b want one-hot-or-zero, pos<=10",
                         i, mot_up, mot_dn, door_open, pos_floor);
            end
        end
    endtask

    // Scenario sequencer.
    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; tgt_valid = 1'b0; tgt_floor = 2'b00;
        model_tick(1'b1, 1'b0, 0);
        test_reset();
        test_ground_to_second();
        test_down_ignore();
        test_same_floor();
        test_reset_mid_travel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_motion_ctrl.md
# elevator_motion_ctrl

Downstream stage of the floor-request FSM: consumes the selected target floor (its next-floor code plus a "button active" strobe) and models the physical car. It drives motor up/down, counts per-floor travel time, tracks car position, and holds the door open for a fixed dwell before accepting the next request. The block is the single source of truth for car position in the design.

## Interface

Parameters:
- TRAVEL_CYCLES, default 100_000_000: clock cycles to travel one floor; must be ≥1.
- DOOR_CYCLES, default 150_000_000: clock cycles the door stays open; must be ≥1.
- CNT_W, default 32: timer width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES)-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tgt_floor  in  2  requested floor: 00 ground, 01 first, 10 second; 11 is invalid.
- tgt_valid  in  1  request strobe, level-sampled each cycle (OR of the upstream floor LEDs).
- pos_floor  out  2  current car floor, registered.
- mot_up  out  1  motor drive upward, registered.
- mot_dn  out  1  motor drive downward, registered.
- door_open  out  1  door open, registered.
- busy  out  1  high whenever state ≠ IDLE, registered.
- arrived  out  1  one-cycle pulse on the cycle the car reaches its target.

## Operation

- States: IDLE, MOVE_UP, MOVE_DN, DOOR.
- Internal: 2-bit latched target `tgt_q`, CNT_W-bit timer `cnt`.
- IDLE, when tgt_valid=1 and tgt_floor≠11:
  - tgt_floor > pos_floor: latch target, cnt←0, go MOVE_UP.
  - tgt_floor < pos_floor: latch target, cnt←0, go MOVE_DN.
  - tgt_floor = pos_floor: cnt←0, go DOOR. arrived is not pulsed.
- IDLE, when tgt_valid=0 or tgt_floor=11: stay in IDLE; nothing changes.
- MOVE_UP / MOVE_DN:
  - cnt increments each cycle.
  - When cnt = TRAVEL_CYCLES-1: pos_floor ±1 and cnt←0.
  - If the new pos_floor equals tgt_q: go DOOR and pulse arrived. Otherwise remain in the same move state.
- DOOR:
  - cnt increments each cycle. When cnt = DOOR_CYCLES-1: go IDLE.
  - tgt_valid=1 with tgt_floor = pos_floor restarts the dwell (cnt←0).
- Requests in MOVE_* or DOOR that do not match the above are ignored and not queued. Upstream keeps the LED lit while the button is held, so the request is re-sampled in IDLE.
- Output decode (registered, from next state):
  - mot_up=1 only in MOVE_UP; mot_dn=1 only in MOVE_DN.
  - door_open=1 only in DOOR.
  - mot_up, mot_dn and door_open are mutually exclusive, always.
- pos_floor never leaves the range 00..10 and never wraps. An illegal state encoding recovers to IDLE with outputs cleared and pos_floor unchanged.

## Timing

- Reset (synchronous, at an edge with reset=1):
  - state=IDLE, pos_floor=00, tgt_q=00, cnt=0.
  - mot_up=mot_dn=door_open=busy=arrived=0.
  - Reset has priority over all other inputs, including mid-travel and mid-dwell. Position returns to ground immediately; this is model behaviour and not a physical move.
- Request latency: a request sampled at edge k shows mot_up/mot_dn/door_open and busy from edge k onward (cycle k+1 high).
- Travel: the motor stays high TRAVEL_CYCLES cycles per floor. pos_floor changes at the edge that ends each floor interval. Ground→second takes 2·TRAVEL_CYCLES cycles of mot_up.
- Arrival edge: motor drops, door_open rises, and arrived=1 for exactly that one cycle, all at the same edge.
- door_open stays high DOOR_CYCLES cycles; busy falls at the same edge door_open falls.
- A new request is accepted in the first IDLE cycle, so minimum IDLE occupancy is one cycle.

## Test plan

Use TRAVEL_CYCLES=4, DOOR_CYCLES=3.

- Reset: hold reset 2 cycles with tgt_valid=1, tgt_floor=10 -> all outputs 0 and pos_floor=00 throughout; after release, the request is accepted on the next edge.
- Ground→second: from IDLE at floor 00, one-cycle request tgt_floor=10 -> mot_up high 8 cycles; pos_floor=01 after 4 cycles and 10 after 8; arrived pulses once; door_open high 3 cycles; then busy=0.
- Second→ground, with an ignored request: tgt_floor=00 -> mot_dn high 8 cycles. A tgt_floor=01 request asserted during cycle 3 of travel is ignored: no stop at 01, and pos_floor ends at 00.
- Same-floor and invalid requests:
  - At floor 00, tgt_floor=00 -> door_open 3 cycles, arrived stays 0.
  - Re-asserting tgt_floor=00 on dwell cycle 2 extends door_open to 5 cycles total.
  - tgt_floor=11 in IDLE -> no state change.
- Reset mid-travel: reset during cycle 6 of ground→second -> next edge shows IDLE, pos_floor=00, mot_up=0, arrived never pulsed.
- Mutual-exclusion assertion: across all scenarios, mot_up, mot_dn and door_open are never high together, and arrived pulses at most once per request.
